// File: rtl/rx_frame_pkg.sv
// Shared types and limits for the UART receive frame checker.
// The optional error counters are enabled with the RX_ERR_CNT_EN macro.
package rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN    = 5;
  localparam int DATA_WIDTH_MAX    = 9;
  localparam int STOP_BITS_MIN     = 1;
  localparam int STOP_BITS_MAX     = 2;
  localparam int ERR_CNT_WIDTH_MIN = 1;

  // Value the parity bit must carry given the XOR of the data bits.
  function automatic logic parity_expected(input logic data_xor, input logic par_typ);
    return data_xor ^ par_typ;
  endfunction

endpackage

// File: rtl/rx_err_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
// Used by rx_frame_check only when RX_ERR_CNT_EN is defined.
module rx_err_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != {WIDTH{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/rx_frame_check.sv
// UART receive frame checker: start/data/parity/stop validation from sampler strobes.
// Define RX_ERR_CNT_EN to add saturating glitch/parity/stop error counters.
module rx_frame_check
  import rx_frame_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int STOP_BITS     = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err
`ifdef RX_ERR_CNT_EN
  ,
  input  logic                     cnt_clr,
  output logic [ERR_CNT_WIDTH-1:0] glitch_cnt,
  output logic [ERR_CNT_WIDTH-1:0] par_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] stp_err_cnt
`endif
);

  localparam int                CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  if ((DATA_WIDTH < DATA_WIDTH_MIN) || (DATA_WIDTH > DATA_WIDTH_MAX)) begin : g_bad_data_width
    $error("rx_frame_check: DATA_WIDTH out of range");
  end
  if ((STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX)) begin : g_bad_stop_bits
    $error("rx_frame_check: STOP_BITS out of range");
  end
  if (ERR_CNT_WIDTH < ERR_CNT_WIDTH_MIN) begin : g_bad_cnt_width
    $error("rx_frame_check: ERR_CNT_WIDTH out of range");
  end

  rx_state_e             state_reg, state_next;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_acc_reg;
  logic                  par_en_reg;
  logic                  par_typ_reg;
  logic                  par_flag_reg;
  logic                  stp_flag_reg;
  logic                  stp_cnt_reg;
  logic [DATA_WIDTH-1:0] p_data_reg, p_data_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  strt_glitch_reg, strt_glitch_next;
  logic                  par_err_reg, par_err_next;
  logic                  stp_err_reg, stp_err_next;
  logic                  frame_accept;
  logic                  frame_done;
  logic                  stp_flag_final;

  assign frame_accept   = (state_reg == ST_IDLE) && frame_start;
  assign frame_done     = (state_reg == ST_STOP) && bit_valid && (stp_cnt_reg == LAST_STOP);
  assign stp_flag_final = stp_flag_reg | ~sampled_bit;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (frame_start) state_next = ST_START;
      ST_START:  if (bit_valid) state_next = sampled_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_valid && (bit_cnt_reg == LAST_BIT))
                   state_next = par_en_reg ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_valid) state_next = ST_STOP;
      ST_STOP:   if (frame_done) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Strobes are decided combinationally from the deciding bit_valid and registered below.
  always_comb begin
    busy             = (state_reg != ST_IDLE);
    p_data_next      = p_data_reg;
    data_valid_next  = 1'b0;
    strt_glitch_next = 1'b0;
    par_err_next     = 1'b0;
    stp_err_next     = 1'b0;
    if ((state_reg == ST_START) && bit_valid && sampled_bit) begin
      strt_glitch_next = 1'b1;
    end
    if (frame_done) begin
      if (!par_flag_reg && !stp_flag_final) begin
        data_valid_next = 1'b1;
        p_data_next     = shift_reg;
      end else begin
        par_err_next = par_flag_reg;
        stp_err_next = stp_flag_final;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_acc_reg <= 1'b0;
      par_en_reg     <= 1'b0;
      par_typ_reg    <= 1'b0;
      par_flag_reg   <= 1'b0;
      stp_flag_reg   <= 1'b0;
      stp_cnt_reg    <= 1'b0;
    end else if (frame_accept) begin
      par_en_reg     <= par_en;
      par_typ_reg    <= par_typ;
      bit_cnt_reg    <= '0;
      parity_acc_reg <= 1'b0;
      par_flag_reg   <= 1'b0;
      stp_flag_reg   <= 1'b0;
      stp_cnt_reg    <= 1'b0;
    end else if (bit_valid) begin
      case (state_reg)
        ST_DATA: begin
          shift_reg      <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
          parity_acc_reg <= parity_acc_reg ^ sampled_bit;
          if (bit_cnt_reg != LAST_BIT) bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
        ST_PARITY: par_flag_reg <= (sampled_bit != parity_expected(parity_acc_reg, par_typ_reg));
        ST_STOP: begin
          stp_flag_reg <= stp_flag_final;
          stp_cnt_reg  <= stp_cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data_reg      <= '0;
      data_valid_reg  <= 1'b0;
      strt_glitch_reg <= 1'b0;
      par_err_reg     <= 1'b0;
      stp_err_reg     <= 1'b0;
    end else begin
      p_data_reg      <= p_data_next;
      data_valid_reg  <= data_valid_next;
      strt_glitch_reg <= strt_glitch_next;
      par_err_reg     <= par_err_next;
      stp_err_reg     <= stp_err_next;
    end
  end

  assign p_data      = p_data_reg;
  assign data_valid  = data_valid_reg;
  assign strt_glitch = strt_glitch_reg;
  assign par_err     = par_err_reg;
  assign stp_err     = stp_err_reg;

`ifdef RX_ERR_CNT_EN
  logic [2:0]               err_strobe;
  logic [ERR_CNT_WIDTH-1:0] err_cnt [3];

  assign err_strobe = {stp_err_reg, par_err_reg, strt_glitch_reg};

  for (genvar gi = 0; gi < 3; gi++) begin : g_err_cnt
    rx_err_counter #(.WIDTH(ERR_CNT_WIDTH)) u_cnt (
      .CLK (CLK),
      .RST (RST),
      .clr (cnt_clr),
      .inc (err_strobe[gi]),
      .cnt (err_cnt[gi])
    );
  end

  assign glitch_cnt  = err_cnt[0];
  assign par_err_cnt = err_cnt[1];
  assign stp_err_cnt = err_cnt[2];
`endif

endmodule

// File: tb/tb_rx_frame_check.sv
// Directed bench for rx_frame_check with a strobe scoreboard; two instances cover
// STOP_BITS=1 and STOP_BITS=2. Counter checks run when RX_ERR_CNT_EN is defined.
module tb_rx_frame_check;
  import rx_frame_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic fs [2];
  logic bv [2];
  logic sb [2];
  logic pen [2];
  logic pty [2];
  logic busy0, dv0, gl0, pe0, se0;
  logic busy1, dv1, gl1, pe1, se1;
  logic [7:0] pd0, pd1;
  int n_tests = 0;
  int n_fail  = 0;

`ifdef RX_ERR_CNT_EN
  logic cnt_clr = 1'b0;
  logic [1:0] gcnt0, pcnt0, scnt0, gcnt1, pcnt1, scnt1;
`endif

  rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_WIDTH(2)) dut0 (
    .CLK(CLK), .RST(RST), .frame_start(fs[0]), .bit_valid(bv[0]), .sampled_bit(sb[0]),
    .par_en(pen[0]), .par_typ(pty[0]), .busy(busy0), .p_data(pd0), .data_valid(dv0),
    .strt_glitch(gl0), .par_err(pe0), .stp_err(se0)
`ifdef RX_ERR_CNT_EN
    , .cnt_clr(cnt_clr), .glitch_cnt(gcnt0), .par_err_cnt(pcnt0), .stp_err_cnt(scnt0)
`endif
  );

  rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_WIDTH(2)) dut1 (
    .CLK(CLK), .RST(RST), .frame_start(fs[1]), .bit_valid(bv[1]), .sampled_bit(sb[1]),
    .par_en(pen[1]), .par_typ(pty[1]), .busy(busy1), .p_data(pd1), .data_valid(dv1),
    .strt_glitch(gl1), .par_err(pe1), .stp_err(se1)
`ifdef RX_ERR_CNT_EN
    , .cnt_clr(cnt_clr), .glitch_cnt(gcnt1), .par_err_cnt(pcnt1), .stp_err_cnt(scnt1)
`endif
  );

  typedef struct {
    string      tag;
    logic [3:0] st;   // {data_valid, strt_glitch, par_err, stp_err}
    logic [7:0] pd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t mk(string tag, logic [3:0] st, logic [7:0] pd);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.pd  = pd;
    return e;
  endfunction

  function automatic logic [3:0] strobes(int i);
    return (i == 0) ? {dv0, gl0, pe0, se0} : {dv1, gl1, pe1, se1};
  endfunction

  function automatic logic [7:0] pdata(int i);
    return (i == 0) ? pd0 : pd1;
  endfunction

  function automatic logic busy_of(int i);
    return (i == 0) ? busy0 : busy1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(int i, exp_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(int i, logic b);
    sb[i] = b;
    bv[i] = 1'b1;
    step();
    bv[i] = 1'b0;
    step();
  endtask

  // Sends one frame on instance i. The expectation is queued just before the deciding bit.
  task automatic send_frame(int i, logic start_b, logic [7:0] d, logic p_en, logic p_typ,
                            logic p_bit, logic [1:0] stops, int nstop, exp_t e,
                            bit skip_start = 1'b0, bit chain = 1'b0);
    if (!skip_start) begin
      pen[i] = p_en;
      pty[i] = p_typ;
      fs[i]  = 1'b1;
      step();
      fs[i]  = 1'b0;
      check({e.tag, "_busy_rise"}, 32'(busy_of(i)), 32'd1);
    end
    if (!chain) begin
      pen[i] = ~p_en;
      pty[i] = ~p_typ;
    end
    if (start_b) begin
      push(i, e);
      send_bit(i, 1'b1);
      return;
    end
    send_bit(i, 1'b0);
    fs[i] = 1'b1;   // ignored while busy
    send_bit(i, d[0]);
    fs[i] = 1'b0;
    for (int k = 1; k < 8; k++) send_bit(i, d[k]);
    if (p_en) send_bit(i, p_bit);
    for (int s = 0; s < nstop; s++) begin
      if (s == nstop - 1) begin
        push(i, e);
        sb[i] = stops[s];
        bv[i] = 1'b1;
        step();
        bv[i] = 1'b0;
        if (chain) begin
          fs[i] = 1'b1;
          step();
          fs[i] = 1'b0;
          check({e.tag, "_b2b_busy"}, 32'(busy_of(i)), 32'd1);
        end else begin
          step();
        end
      end else begin
        send_bit(i, stops[s]);
      end
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (strobes(i) != 4'b0000) begin
        if (((i == 0) ? q0.size() : q1.size()) == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL unexpected_strobe dut%0d: observed 0x%0h expected 0x0", i, strobes(i));
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check({e.tag, "_strobes"}, 32'(strobes(i)), 32'(e.st));
          check({e.tag, "_p_data"}, 32'(pdata(i)), 32'(e.pd));
          check({e.tag, "_busy_low"}, 32'(busy_of(i)), 32'd0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      fs[i] = 1'b0; bv[i] = 1'b0; sb[i] = 1'b1; pen[i] = 1'b0; pty[i] = 1'b0;
    end
    repeat (3) step();
    check("reset_strobes", 32'(strobes(0)), 32'd0);
    check("reset_p_data", 32'(pd0), 32'd0);
    check("reset_busy", 32'(busy0), 32'd0);
    RST = 1'b1;
    step();

    send_frame(0, 1'b0, 8'hA5, 1'b1, PAR_EVEN, 1'b0, 2'b11, 1, mk("good_a5", 4'b1000, 8'hA5));

    send_frame(0, 1'b1, 8'h00, 1'b0, PAR_EVEN, 1'b0, 2'b11, 1, mk("glitch", 4'b0100, 8'hA5));
    check("glitch_busy", 32'(busy0), 32'd0);
    for (int k = 0; k < 10; k++) send_bit(0, 1'(k));
    check("idle_bits_strobes", 32'(strobes(0)), 32'd0);
    check("idle_bits_busy", 32'(busy0), 32'd0);

    send_frame(0, 1'b0, 8'h3C, 1'b1, PAR_ODD, 1'b0, 2'b11, 1, mk("odd_par_err", 4'b0010, 8'hA5));
    send_frame(0, 1'b0, 8'h81, 1'b1, PAR_EVEN, 1'b1, 2'b00, 1, mk("par_stp_err", 4'b0011, 8'hA5));

    pen[0] = 1'b0; fs[0] = 1'b1; bv[0] = 1'b1; sb[0] = 1'b0;
    step();
    fs[0] = 1'b0; bv[0] = 1'b0;
    send_frame(0, 1'b0, 8'h96, 1'b0, PAR_EVEN, 1'b0, 2'b11, 1, mk("fs_bv_same", 4'b1000, 8'h96),
               1'b1, 1'b0);

    send_frame(0, 1'b0, 8'h3C, 1'b1, PAR_ODD, 1'b1, 2'b11, 1, mk("b2b_first", 4'b1000, 8'h3C),
               1'b0, 1'b1);
    send_frame(0, 1'b0, 8'h00, 1'b1, PAR_ODD, 1'b1, 2'b11, 1, mk("b2b_second", 4'b1000, 8'h00),
               1'b1, 1'b0);

    send_frame(1, 1'b0, 8'h0F, 1'b0, PAR_EVEN, 1'b0, 2'b01, 2, mk("stop2_err", 4'b0001, 8'h00));
    send_frame(1, 1'b0, 8'h0F, 1'b0, PAR_EVEN, 1'b0, 2'b11, 2, mk("stop2_good", 4'b1000, 8'h0F));

    send_frame(0, 1'b0, 8'hC3, 1'b0, PAR_EVEN, 1'b0, 2'b11, 1, mk("pre_reset", 4'b1000, 8'hC3));
    pen[0] = 1'b0; fs[0] = 1'b1;
    step();
    fs[0] = 1'b0;
    send_bit(0, 1'b0);
    for (int k = 0; k < 4; k++) send_bit(0, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    check("mid_reset_strobes", 32'(strobes(0)), 32'd0);
    check("mid_reset_p_data", 32'(pd0), 32'd0);
    check("mid_reset_busy", 32'(busy0), 32'd0);
    step();
    RST = 1'b1;
    step();
    send_frame(0, 1'b0, 8'h5A, 1'b0, PAR_EVEN, 1'b0, 2'b11, 1, mk("post_reset_5a", 4'b1000, 8'h5A));

`ifdef RX_ERR_CNT_EN
    for (int k = 0; k < 5; k++)
      send_frame(0, 1'b1, 8'h00, 1'b0, PAR_EVEN, 1'b0, 2'b11, 1, mk("cnt_glitch", 4'b0100, 8'h5A));
    check("glitch_cnt_sat", 32'(gcnt0), 32'd3);
    check("par_err_cnt_zero", 32'(pcnt0), 32'd0);
    check("stp_err_cnt_zero", 32'(scnt0), 32'd0);
    fs[0] = 1'b1;
    step();
    fs[0] = 1'b0;
    push(0, mk("clr_glitch", 4'b0100, 8'h5A));
    sb[0] = 1'b1; bv[0] = 1'b1;
    step();
    bv[0] = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("glitch_cnt_clr_wins", 32'(gcnt0), 32'd0);
`endif

    repeat (4) step();
    check("scoreboard0_drained", 32'(q0.size()), 32'd0);
    check("scoreboard1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_check.md
# rx_frame_check

Parametrised UART receive frame checker that generalises the single start-glitch flag into full frame validation. It sits after the RX edge detector and data sampler and tracks the frame position from sampler strobes. It checks the start bit, assembles DATA_WIDTH data bits LSB-first, and checks optional even/odd parity and one or two stop bits. It reports the frame as valid or in error with single-cycle registered strobes.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- ERR_CNT_WIDTH, 8, width of the error counters; used only with RX_ERR_CNT_EN.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse from the edge detector marking a candidate start bit.
- bit_valid  in  1  one-cycle strobe: sampled_bit holds the current bit's sampled value.
- sampled_bit  in  1  majority-sampled line value.
- par_en  in  1  parity bit present; latched at an accepted frame_start.
- par_typ  in  1  0 = even, 1 = odd; latched at an accepted frame_start.
- busy  out  1  high while a frame is being tracked, i.e. FSM not in IDLE.
- p_data  out  DATA_WIDTH  last good frame's data; holds until the next data_valid.
- data_valid  out  1  one-cycle pulse: frame received with no errors.
- strt_glitch  out  1  one-cycle pulse: start bit sampled as 1.
- par_err  out  1  one-cycle pulse: parity mismatch.
- stp_err  out  1  one-cycle pulse: a stop bit was sampled as 0.
- cnt_clr, glitch_cnt, par_err_cnt, stp_err_cnt: present only with RX_ERR_CNT_EN (see Configuration).

## Operation
FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - bit_valid is ignored.
  - On frame_start, latch par_en/par_typ, clear bit_cnt and parity_acc, and go to START.
- START:
  - On bit_valid with sampled_bit=1, pulse strt_glitch and go to IDLE.
  - On bit_valid with sampled_bit=0, go to DATA.
- DATA:
  - On each bit_valid, shift sampled_bit into the MSB of the shift register (shift right).
  - Update parity_acc ^= sampled_bit and increment bit_cnt.
  - On the bit_valid where bit_cnt == DATA_WIDTH-1, go to PARITY if the latched par_en is 1, else STOP.
- PARITY:
  - On bit_valid, set par_flag = sampled_bit != (parity_acc ^ par_typ_latched), then go to STOP.
- STOP:
  - On each bit_valid, set stp_flag |= ~sampled_bit and count stop bits.
  - On the STOP_BITS-th stop bit, go to IDLE and issue the frame result.
- Frame result:
  - If par_flag=0 and stp_flag=0: data_valid=1 and p_data is loaded from the shift register.
  - Otherwise: par_err=par_flag and stp_err=stp_flag; both may pulse together; p_data is unchanged.
- frame_start while busy is ignored.
- frame_start and bit_valid in the same cycle in IDLE: frame_start is taken; that bit_valid is not counted.
- Width rules:
  - bit_cnt is $clog2(DATA_WIDTH) bits and never wraps past DATA_WIDTH-1.
  - Stop counter is 1 bit.

## Timing
- Reset: all outputs are 0, p_data=0, FSM in IDLE, all internal flags and counters cleared.
- Reset is effective immediately, including mid-frame; the partial frame is discarded and no strobe is issued.
- strt_glitch, data_valid, par_err, stp_err are registered and assert exactly one cycle after the deciding bit_valid edge.
- busy rises the cycle after an accepted frame_start. It falls in the same cycle the result strobe asserts.
- Back-to-back frames: a frame_start in the cycle the result strobe is high is accepted.
- No output strobe ever lasts more than one cycle.

## Configuration
- RX_ERR_CNT_EN defined:
  - Adds input cnt_clr (1 bit, synchronous clear) and outputs glitch_cnt, par_err_cnt, stp_err_cnt (ERR_CNT_WIDTH each).
  - Each counter increments on its strobe and saturates at all-ones.
  - If cnt_clr and a strobe occur in the same cycle, cnt_clr wins.
  - Counters reset to 0.
- RX_ERR_CNT_EN undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Package rx_frame_pkg:
  - FSM state enum.
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1.
  - Parameter-range limits used by elaboration-time checks.
- Sub-module rx_err_counter: saturating counter with clear, parametrised by width, instantiated three times under RX_ERR_CNT_EN.

## Test plan
- DATA_WIDTH=8, even parity, 0xA5 with parity bit 0 and stop 1 -> data_valid=1 for one cycle, p_data=0xA5, no error strobes.
- Start bit sampled 1 -> strt_glitch=1 for one cycle, busy=0; the next 10 bit_valids produce no strobes.
- Odd parity, 0x3C with parity bit 0 (expected 1) -> par_err=1, data_valid=0, p_data stays 0xA5.
- STOP_BITS=2, 0x0F, first stop 1 and second stop 0 -> stp_err=1 one cycle after the second stop bit_valid; busy is 0 in that cycle.
- RST low after 4 data bits -> all outputs 0 at once; the next full frame 0x5A gives data_valid with p_data=0x5A.
- RX_ERR_CNT_EN, ERR_CNT_WIDTH=2, five glitches -> glitch_cnt=3 (saturated); cnt_clr together with a sixth glitch -> glitch_cnt=0.
